// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream valid/ready/data in, downstream valid/ready/data out.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register chain: STAGES valid-tagged data registers joined by valid/ready,
// with bubble collapse, synchronous flush and a registered occupancy count.
module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  pipe_reg_chain_if.slave  bus,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d     [STAGES];
  logic [STAGES-1:0] r;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];
  logic              in_fire;
  logic              out_fire;

  // A stage can take new data if it is empty or its successor is taking its contents.
  always_comb begin
    logic rdy;
    r   = '0;
    rdy = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy  = !v[k] | rdy;
      r[k] = rdy;
    end
  end

  always_comb begin
    src_v[0] = bus.in_valid & !flush;
    src_d[0] = bus.in_data;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = d[k-1];
    end
  end

  assign bus.in_ready  = r[0] & !flush;
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_data  = d[STAGES-1];
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  // Data registers keep their last value when a bubble passes through, so idle data stays deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v         <= '0;
      occupancy <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= RESET_VAL;
      end
    end else if (flush) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (r[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) begin
            d[k] <= src_d[k];
          end
        end
      end
      case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: a 3-stage and a 1-stage chain driven with directed vectors.
module tb_pipe_reg_chain;

  logic       clk;
  logic       reset_n;
  logic       flushA;
  logic       flushB;
  logic [1:0] occA;
  logic [0:0] occB;
  int         total;
  int         bad;
  logic [7:0] expA [$];
  logic [7:0] expB [$];

  pipe_reg_chain_if #(.WIDTH(8)) ifA ();
  pipe_reg_chain_if #(.WIDTH(8)) ifB ();

  pipe_reg_chain #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hA5)) dutA (
    .clk(clk), .reset_n(reset_n), .flush(flushA), .bus(ifA), .occupancy(occA)
  );

  pipe_reg_chain #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'h5A)) dutB (
    .clk(clk), .reset_n(reset_n), .flush(flushB), .bus(ifB), .occupancy(occB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Offer one item; when it is accepted its expected output joins the scoreboard queue if tracked.
  task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit track);
    int   waitCycles;
    logic rdy;
    waitCycles = 0;
    if (sel) begin ifB.in_valid = 1'b1; ifB.in_data = data; end
    else     begin ifA.in_valid = 1'b1; ifA.in_data = data; end
    @(negedge clk);
    rdy = sel ? ifB.in_ready : ifA.in_ready;
    while (!rdy && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
      rdy = sel ? ifB.in_ready : ifA.in_ready;
    end
    checkOutput("accept", {31'b0, rdy}, 32'd1);
    if (rdy && track) begin
      if (sel) expB.push_back(data);
      else     expA.push_back(data);
    end
    @(posedge clk); #1;
    if (sel) ifB.in_valid = 1'b0;
    else     ifA.in_valid = 1'b0;
  endtask

  task automatic waitEmpty(input bit sel);
    int n;
    n = 0;
    while (((sel ? 2'(occB) : occA) != 2'd0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (sel) checkOutput("drainB", 32'(occB), 32'd0);
    else     checkOutput("drainA", 32'(occA), 32'd0);
  endtask

  always @(negedge clk) begin
    if (ifA.out_valid && ifA.out_ready) begin
      if (expA.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL scoreboardA: got=%0h expected=none", ifA.out_data);
      end else begin
        checkOutput("scoreboardA", 32'(ifA.out_data), 32'(expA.pop_front()));
      end
    end
    if (ifB.out_valid && ifB.out_ready) begin
      if (expB.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL scoreboardB: got=%0h expected=none", ifB.out_data);
      end else begin
        checkOutput("scoreboardB", 32'(ifB.out_data), 32'(expB.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b1; flushA = 1'b0; flushB = 1'b0;
    ifA.in_valid = 1'b0; ifA.in_data = 8'h00; ifA.out_ready = 1'b0;
    ifB.in_valid = 1'b0; ifB.in_data = 8'h00; ifB.out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rstA out_valid", 32'(ifA.out_valid), 32'd0);
    checkOutput("rstA out_data", 32'(ifA.out_data), 32'hA5);
    checkOutput("rstA occupancy", 32'(occA), 32'd0);
    checkOutput("rstA in_ready", 32'(ifA.in_ready), 32'd1);
    checkOutput("rstB out_data", 32'(ifB.out_data), 32'h5A);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset with full chain");
    applyStimulus(0, 8'h40, 0);
    applyStimulus(0, 8'h41, 0);
    applyStimulus(0, 8'h42, 0);
    checkOutput("prefill occupancy", 32'(occA), 32'd3);
    checkOutput("prefill out_data", 32'(ifA.out_data), 32'h40);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", 32'(ifA.out_valid), 32'd0);
    checkOutput("midrst out_data", 32'(ifA.out_data), 32'hA5);
    checkOutput("midrst occupancy", 32'(occA), 32'd0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postrst out_valid", 32'(ifA.out_valid), 32'd0);

    $display("[TB] streaming");
    ifA.out_ready = 1'b1;
    fork
      for (int i = 1; i <= 10; i++) applyStimulus(0, 8'(i), 1);
      begin
        @(posedge clk); #2;
        checkOutput("latency e1 valid", 32'(ifA.out_valid), 32'd0);
        @(posedge clk); #2;
        checkOutput("latency e2 valid", 32'(ifA.out_valid), 32'd0);
        @(posedge clk); #2;
        checkOutput("latency e3 valid", 32'(ifA.out_valid), 32'd1);
        checkOutput("latency e3 data", 32'(ifA.out_data), 32'h01);
      end
      repeat (10) begin
        @(negedge clk);
        checkOutput("stream in_ready", 32'(ifA.in_ready), 32'd1);
      end
    join
    checkOutput("stream occupancy", 32'(occA), 32'd3);
    waitEmpty(0);

    $display("[TB] backpressure");
    ifA.out_ready = 1'b0;
    applyStimulus(0, 8'h10, 1);
    @(posedge clk); #1;
    applyStimulus(0, 8'h11, 1);
    applyStimulus(0, 8'h12, 1);
    ifA.in_valid = 1'b1; ifA.in_data = 8'h13;
    repeat (2) begin
      @(negedge clk);
      checkOutput("bp in_ready low", 32'(ifA.in_ready), 32'd0);
    end
    checkOutput("bp occupancy", 32'(occA), 32'd3);
    checkOutput("bp head", 32'(ifA.out_data), 32'h10);
    @(posedge clk); #1;
    ifA.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release in_ready", 32'(ifA.in_ready), 32'd1);
    if (ifA.in_ready) expA.push_back(8'h13);
    @(posedge clk); #1;
    ifA.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp consecutive", 32'(ifA.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    waitEmpty(0);

    $display("[TB] full with simultaneous fire");
    ifA.out_ready = 1'b0;
    applyStimulus(0, 8'h20, 1);
    applyStimulus(0, 8'h21, 1);
    applyStimulus(0, 8'h22, 1);
    checkOutput("full occupancy", 32'(occA), 32'd3);
    ifA.out_ready = 1'b1; ifA.in_valid = 1'b1; ifA.in_data = 8'h23;
    #1;
    checkOutput("full in_ready", 32'(ifA.in_ready), 32'd1);
    applyStimulus(0, 8'h23, 1);
    checkOutput("full occupancy kept", 32'(occA), 32'd3);
    checkOutput("full next head", 32'(ifA.out_data), 32'h21);
    waitEmpty(0);

    $display("[TB] flush");
    ifA.out_ready = 1'b0;
    applyStimulus(0, 8'h30, 1);
    applyStimulus(0, 8'h31, 0);
    @(posedge clk); #1;
    checkOutput("preflush occupancy", 32'(occA), 32'd2);
    flushA = 1'b1; ifA.in_valid = 1'b1; ifA.in_data = 8'h32; ifA.out_ready = 1'b1;
    #1;
    checkOutput("flush in_ready", 32'(ifA.in_ready), 32'd0);
    checkOutput("flush head valid", 32'(ifA.out_valid), 32'd1);
    @(posedge clk); #1;
    flushA = 1'b0; ifA.in_valid = 1'b0;
    checkOutput("postflush out_valid", 32'(ifA.out_valid), 32'd0);
    checkOutput("postflush occupancy", 32'(occA), 32'd0);
    @(posedge clk); #1;
    checkOutput("postflush2 out_valid", 32'(ifA.out_valid), 32'd0);
    checkOutput("postflush2 occupancy", 32'(occA), 32'd0);

    $display("[TB] single stage");
    ifB.out_ready = 1'b0;
    applyStimulus(1, 8'h50, 1);
    checkOutput("s1 in_ready held", 32'(ifB.in_ready), 32'd0);
    checkOutput("s1 out_valid", 32'(ifB.out_valid), 32'd1);
    checkOutput("s1 occupancy", 32'(occB), 32'd1);
    ifB.out_ready = 1'b1;
    fork
      for (int i = 1; i <= 4; i++) applyStimulus(1, 8'(8'h50 + i), 1);
      begin
        @(posedge clk); #2;
        checkOutput("s1 latency valid", 32'(ifB.out_valid), 32'd1);
        checkOutput("s1 latency data", 32'(ifB.out_data), 32'h51);
      end
      repeat (4) begin
        @(negedge clk);
        checkOutput("s1 stream in_ready", 32'(ifB.in_ready), 32'd1);
      end
    join
    waitEmpty(1);

    @(posedge clk); #1;
    checkOutput("scoreboardA drained", 32'(expA.size()), 32'd0);
    checkOutput("scoreboardB drained", 32'(expB.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register: a chain of STAGES data registers, each with its own valid bit, joined by valid/ready handshakes.
- Successor to the plain enable-gated flip-flop used between CPU pipeline stages. Adds depth, per-stage valid tracking, backpressure with bubble collapse, synchronous flush, occupancy count and a configurable data reset value.
- Used to retime datapaths between CPU pipeline stages and to absorb stalls.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- STAGES, 2, number of register stages (>=1); nominal latency in cycles.
- RESET_VAL, '0, WIDTH-bit value loaded into every data register on reset.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush: invalidates all stages.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  chain can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  stage STAGES-1 holds valid data.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  data of stage STAGES-1.
- occupancy  output  $clog2(STAGES+1)  number of valid stages (registered).

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed):
  - all v[k]=0, all d[k]=RESET_VAL, occupancy=0.
  - Outputs: out_valid=0, out_data=RESET_VAL, in_ready=1 (out_ready/flush permitting per rules below).
  - Deassertion takes effect at the first rising edge with reset_n=1.
- Stage indexing: stage 0 is the input side, stage STAGES-1 drives out_valid/out_data directly from its registers (no combinational data path).
- Ready chain (combinational):
  - r[STAGES]=out_ready; r[k] = !v[k] | r[k+1].
  - in_ready = r[0] & !flush.
  - Combinational path out_ready->in_ready is permitted; its depth is STAGES.
- Per-edge update, stage k:
  - src valid = in_valid & !flush for k=0, else v[k-1].
  - If r[k]=1: v[k] <= src valid; d[k] <= src data only when src valid=1. Otherwise d[k] holds.
  - If r[k]=0: v[k] and d[k] hold.
- Transfers:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - Data order is strictly FIFO; no item is duplicated or dropped except by flush.
- Latency and throughput:
  - Item accepted at edge t is presented on out_valid in the cycle after edge t+STAGES-1, i.e. STAGES cycles, with out_ready held 1.
  - Throughput is 1 item/cycle sustained.
- Bubble collapse: with out_ready=0, upstream items advance into empty stages until all STAGES are full; then in_ready=0.
- Flush (synchronous, highest priority):
  - In a flush cycle in_ready=0, so no input fire occurs.
  - An output fire in that cycle still completes.
  - At the edge: all v[k] <= 0, occupancy <= 0. d[k] are not cleared.
  - flush held several cycles keeps the chain empty.
- Occupancy counter:
  - Without flush: +1 on input fire only, -1 on output fire only, unchanged on both or neither.
  - Must always equal popcount(v) after each edge; range 0..STAGES.
- Full chain with out_ready=1: simultaneous input and output fire, all stages shift, occupancy unchanged.
- Reset mid-operation: all in-flight items discarded immediately; no out_valid glitch after reset assertion.
- Data values while v[k]=0 are don't-care to consumers. They remain deterministic: last loaded value or RESET_VAL.

Test Plan (WIDTH=8, STAGES=3, RESET_VAL=8'hA5 unless stated):
- Reset: assert reset_n=0 mid-clock with chain full -> out_valid=0, out_data=8'hA5, occupancy=0 immediately, before any edge.
- Streaming: out_ready=1, send 8'h01..8'h0A back-to-back -> 8'h01 appears 3 cycles after acceptance, then one item per cycle in order; in_ready stays 1; occupancy settles at 3.
- Backpressure/bubble collapse: send 8'h10, idle one cycle, send 8'h11, 8'h12, 8'h13 with out_ready=0 -> in_ready drops after 3 accepted items, 8'h13 stalls upstream, occupancy=3. Release out_ready -> 8'h10, 8'h11, 8'h12, 8'h13 emitted in consecutive cycles.
- Full + simultaneous: chain full of 8'h20, 8'h21, 8'h22, out_ready=1, in_valid=1 with 8'h23 -> 8'h20 out, 8'h23 accepted the same cycle, occupancy stays 3.
- Flush: chain holding 2 items, assert flush with in_valid=1, out_ready=1 -> in_ready=0 that cycle; head item transfers; next cycle out_valid=0, occupancy=0; the input item is not captured.
- STAGES=1 variant: out_ready=0 with one item held -> in_ready=0. Toggle out_ready=1 with in_valid=1 -> pass-through at 1 item/cycle with 1-cycle latency.
